psum_line_accumulator: RTL

//  Sits directly downstream of the line conv2d engine's per-kernel psum outputs (kn0..kn3).

---
 rtl/psum_line_accumulator_pkg.sv | 51 +++++
 rtl/psum_line_accumulator_lane.sv | 138 +++++++++++++
 rtl/psum_line_accumulator.sv | 68 ++++++
 3 files changed

// File: rtl/psum_line_accumulator_pkg.sv
// Shared definitions for the psum line accumulator.
//  - default sizing of the accumulator and line buffer
//  - bit positions inside the control register
//  - control struct handed from the top to every lane
//  - saturate / requantize helpers used by the lane output stage
package psum_line_accumulator_pkg;

  localparam int BIT_WIDTH_DEF  = 8;
  localparam int NUM_KERNEL_DEF = 4;
  localparam int ACC_WIDTH_DEF  = 16;
  localparam int MAX_LINE_DEF   = 32;
  localparam int LEN_WIDTH_DEF  = 6;
  localparam int PASS_WIDTH_DEF = 4;
  localparam int REG_WIDTH_DEF  = 32;

  // control register fields
  localparam int CTRL_EN       = 0;
  localparam int CTRL_RELU     = 1;
  localparam int CTRL_SHIFT_LO = 2;
  localparam int CTRL_SHIFT_W  = 4;
  localparam int CTRL_USED_W   = CTRL_SHIFT_LO + CTRL_SHIFT_W;

  typedef struct packed {
    logic                    enable;
    logic                    relu;
    logic [CTRL_SHIFT_W-1:0] shift;
  } ctrl_t;

  // clamp a signed value into the signed range of a w-bit word
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  // arithmetic (truncating) shift, optional ReLU, then saturate to w bits
  function automatic logic signed [31:0] requant(input logic signed [31:0]   sum,
                                                 input logic [CTRL_SHIFT_W-1:0] shift,
                                                 input logic                  relu,
                                                 input int                    w);
    logic signed [31:0] q;
    q = sum >>> shift;
    if (relu && (q < 0)) q = '0;
    return sat_signed(q, w);
  endfunction

endpackage

// File: rtl/psum_line_accumulator_lane.sv
// One kernel lane of the psum line accumulator.
//  Accumulates num_pass psums per position across a line of line_len positions in a
//  small async-read / sync-write line buffer, and on the last pass requantizes the sum
//  into a registered activation (1 cycle latency, one valid per cycle).
// Ports
//  clk, rst        clock, synchronous active-high reset
//  ctrl            enable / relu / shift from the control register
//  line_len        positions per line (0 -> 1, >MAX_LINE -> MAX_LINE)
//  num_pass        psums per position (0 -> 1)
//  psum, psum_val  incoming partial sum and its valid
//  data, data_val  requantized activation and its 1-cycle valid
//  line_done       pulses with the final output of a line
//  err_sat         sticky accumulator-saturation flag
module psum_acc_lane
  import psum_line_accumulator_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int MAX_LINE   = MAX_LINE_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int PASS_WIDTH = PASS_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  ctrl_t                       ctrl,
  input  logic [LEN_WIDTH-1:0]        line_len,
  input  logic [PASS_WIDTH-1:0]       num_pass,
  input  logic signed [BIT_WIDTH-1:0] psum,
  input  logic                        psum_val,
  output logic signed [BIT_WIDTH-1:0] data,
  output logic                        data_val,
  output logic                        line_done,
  output logic                        err_sat
);

  localparam int POS_W = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] mem [MAX_LINE];

  logic [POS_W-1:0]        pos, last_pos_q;
  logic [PASS_WIDTH-1:0]   pass, last_pass_q;
  logic [CTRL_SHIFT_W-1:0] shift_q;
  logic                    relu_q;

  logic                        accept, start;
  logic [LEN_WIDTH-1:0]        len_c;
  logic [POS_W-1:0]            last_pos_new, last_pos;
  logic [PASS_WIDTH-1:0]       last_pass_new, last_pass;
  logic [CTRL_SHIFT_W-1:0]     shift_e;
  logic                        relu_e;
  logic signed [ACC_WIDTH-1:0] base, sum;
  logic signed [ACC_WIDTH:0]   wide;
  logic                        ovf, is_last_pos, is_last_pass;
  logic signed [BIT_WIDTH-1:0] q;

  assign accept = ctrl.enable && psum_val;
  // first valid of a line: config for this line is taken from the live inputs
  assign start  = (pos == '0) && (pass == '0);

  always_comb begin
    len_c = line_len;
    if (line_len == '0)                          len_c = LEN_WIDTH'(1);
    else if (line_len > LEN_WIDTH'(MAX_LINE))    len_c = LEN_WIDTH'(MAX_LINE);
  end

  assign last_pos_new  = POS_W'(len_c - LEN_WIDTH'(1));
  assign last_pass_new = (num_pass == '0) ? '0 : num_pass - PASS_WIDTH'(1);

  assign last_pos  = start ? last_pos_new  : last_pos_q;
  assign last_pass = start ? last_pass_new : last_pass_q;
  assign shift_e   = start ? ctrl.shift    : shift_q;
  assign relu_e    = start ? ctrl.relu     : relu_q;

  // pass 0 never reads the buffer, so stale contents from an aborted line are harmless
  assign base = (pass == '0) ? '0 : mem[pos];
  assign wide = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(psum);
  assign ovf  = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];

  always_comb begin
    sum = wide[ACC_WIDTH-1:0];
    if (ovf) sum = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  assign is_last_pos  = pos  == last_pos;
  assign is_last_pass = pass == last_pass;
  assign q = BIT_WIDTH'(requant(32'(sum), shift_e, relu_e, BIT_WIDTH));

  // single-cycle read-modify-write: line_len==1 back-to-back needs no bypass
  always_ff @(posedge clk) begin
    if (!rst && accept && !is_last_pass) mem[pos] <= sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos         <= '0;
      pass        <= '0;
      last_pos_q  <= '0;
      last_pass_q <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      data        <= '0;
      data_val    <= 1'b0;
      line_done   <= 1'b0;
      err_sat     <= 1'b0;
    end else begin
      data_val  <= 1'b0;
      line_done <= 1'b0;
      if (accept) begin
        if (start) begin
          last_pos_q  <= last_pos_new;
          last_pass_q <= last_pass_new;
          shift_q     <= ctrl.shift;
          relu_q      <= ctrl.relu;
        end
        if (ovf) err_sat <= 1'b1;
        if (is_last_pass) begin
          data     <= q;
          data_val <= 1'b1;
        end
        if (is_last_pos) begin
          pos <= '0;
          if (is_last_pass) begin
            pass      <= '0;
            line_done <= 1'b1;
          end else begin
            pass <= pass + PASS_WIDTH'(1);
          end
        end else begin
          pos <= pos + POS_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/psum_line_accumulator.sv
// Psum line accumulator: NUM_KERNEL independent lanes sitting behind the line conv2d
// engine's per-kernel psum outputs. This level only decodes the control register,
// slices the packed buses and fans out clock/reset/config to the lanes.
// Ports
//  clk, rst          clock, synchronous active-high reset
//  i_conf_ctrl       [0] enable, [1] ReLU enable, [5:2] shift
//  i_conf_line_len   positions per line
//  i_conf_num_pass   psums accumulated per position
//  i_psum/_val       packed per-lane psums (lane k at [k*BIT_WIDTH +: BIT_WIDTH]) + valids
//  o_data/_val       packed per-lane activations + valid pulses
//  o_line_done       per-lane end-of-line pulse
//  o_err_sat         per-lane sticky accumulator saturation
module psum_line_accumulator
  import psum_line_accumulator_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int NUM_KERNEL = NUM_KERNEL_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int MAX_LINE   = MAX_LINE_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int PASS_WIDTH = PASS_WIDTH_DEF,
  parameter int REG_WIDTH  = REG_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REG_WIDTH-1:0]            i_conf_ctrl,
  input  logic [LEN_WIDTH-1:0]            i_conf_line_len,
  input  logic [PASS_WIDTH-1:0]           i_conf_num_pass,
  input  logic [BIT_WIDTH*NUM_KERNEL-1:0] i_psum,
  input  logic [NUM_KERNEL-1:0]           i_psum_val,
  output logic [BIT_WIDTH*NUM_KERNEL-1:0] o_data,
  output logic [NUM_KERNEL-1:0]           o_data_val,
  output logic [NUM_KERNEL-1:0]           o_line_done,
  output logic [NUM_KERNEL-1:0]           o_err_sat
);

  ctrl_t ctrl;
  logic  unused_ctrl;

  assign ctrl.enable = i_conf_ctrl[CTRL_EN];
  assign ctrl.relu   = i_conf_ctrl[CTRL_RELU];
  assign ctrl.shift  = i_conf_ctrl[CTRL_SHIFT_LO +: CTRL_SHIFT_W];
  // upper control bits are reserved
  assign unused_ctrl = ^i_conf_ctrl[REG_WIDTH-1:CTRL_USED_W];

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
    psum_acc_lane #(
      .BIT_WIDTH (BIT_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .MAX_LINE  (MAX_LINE),
      .LEN_WIDTH (LEN_WIDTH),
      .PASS_WIDTH(PASS_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ctrl     (ctrl),
      .line_len (i_conf_line_len),
      .num_pass (i_conf_num_pass),
      .psum     (i_psum[k*BIT_WIDTH +: BIT_WIDTH]),
      .psum_val (i_psum_val[k]),
      .data     (o_data[k*BIT_WIDTH +: BIT_WIDTH]),
      .data_val (o_data_val[k]),
      .line_done(o_line_done[k]),
      .err_sat  (o_err_sat[k])
    );
  end

endmodule
